// File: rtl/wb_mem_sched.sv
// Shared-memory Wishbone arbiter for m0 (vcache) and m1 (cpu); m1 wins after STARVE_MAX back-to-back m0 grants.
// Latency: grant registered 1 cycle after cyc, ack/read data combinational, 1-cycle IDLE gap between owners.
// Backpressure: owner stalls until slave ack; ARB_WATCHDOG_EN adds a stb-without-ack timeout that errors and releases.
module wb_mem_sched #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64,
    parameter int AW         = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] wb_m0_adr_i,
    input  logic [31:0]   wb_m0_dat_i,
    input  logic [3:0]    wb_m0_sel_i,
    input  logic          wb_m0_cyc_i,
    input  logic          wb_m0_stb_i,
    input  logic          wb_m0_we_i,
    output logic [31:0]   wb_m0_dat_o,
    output logic          wb_m0_ack_o,
    output logic          wb_m0_err_o,
    input  logic [AW-1:0] wb_m1_adr_i,
    input  logic [31:0]   wb_m1_dat_i,
    input  logic [3:0]    wb_m1_sel_i,
    input  logic          wb_m1_cyc_i,
    input  logic          wb_m1_stb_i,
    input  logic          wb_m1_we_i,
    output logic [31:0]   wb_m1_dat_o,
    output logic          wb_m1_ack_o,
    output logic          wb_m1_err_o,
    output logic [AW-1:0] wb_s_adr_o,
    output logic [31:0]   wb_s_dat_o,
    output logic [3:0]    wb_s_sel_o,
    output logic          wb_s_cyc_o,
    output logic          wb_s_stb_o,
    output logic          wb_s_we_o,
    input  logic [31:0]   wb_s_dat_i,
    input  logic          wb_s_ack_i,
    output logic [1:0]    mst_sel,
    output logic [2:0]    starve_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [2:0] starve_q, starve_nxt;
    logic       own0, own1, own_cyc, own_stb, timeout;

    assign own0    = (state == OWN0);
    assign own1    = (state == OWN1);
    assign own_cyc = (own0 & wb_m0_cyc_i) | (own1 & wb_m1_cyc_i);
    assign own_stb = (own0 & wb_m0_stb_i) | (own1 & wb_m1_stb_i);

`ifdef ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;

    // Fires in the TIMEOUT-th strobe cycle that has seen no ack.
    assign timeout = own_stb && !wb_s_ack_i && (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk) begin
        if (wb_rst || state == IDLE || state_nxt == IDLE) begin
            wd_cnt <= '0;
        end else if (wb_s_ack_i) begin
            wd_cnt <= '0;
        end else if (own_stb) begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state    <= IDLE;
            starve_q <= '0;
        end else begin
            state    <= state_nxt;
            starve_q <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_q;
        case (state)
            IDLE: begin
                if (wb_m0_cyc_i && (!wb_m1_cyc_i || starve_q < SMAX)) begin
                    state_nxt = OWN0;
                end else if (wb_m1_cyc_i) begin
                    state_nxt = OWN1;
                end
                // Streak only counts m0 wins taken while m1 was actually waiting.
                if (state_nxt == OWN1 || !wb_m1_cyc_i) begin
                    starve_nxt = '0;
                end else if (state_nxt == OWN0 && starve_q < SMAX) begin
                    starve_nxt = starve_q + 3'd1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wb_s_adr_o  = own1 ? wb_m1_adr_i : wb_m0_adr_i;
    assign wb_s_dat_o  = own1 ? wb_m1_dat_i : wb_m0_dat_i;
    assign wb_s_sel_o  = own1 ? wb_m1_sel_i : wb_m0_sel_i;
    assign wb_s_we_o   = (own0 & wb_m0_we_i) | (own1 & wb_m1_we_i);
    assign wb_s_cyc_o  = own_cyc & ~timeout;
    assign wb_s_stb_o  = own_stb & ~timeout;

    assign wb_m0_dat_o = wb_s_dat_i;
    assign wb_m1_dat_o = wb_s_dat_i;
    assign wb_m0_ack_o = wb_s_ack_i & own0;
    assign wb_m1_ack_o = wb_s_ack_i & own1;
    assign wb_m0_err_o = timeout & own0;
    assign wb_m1_err_o = timeout & own1;

    assign mst_sel     = {own1, own0};
    assign starve_cnt  = starve_q;
endmodule

// File: doc/wb_mem_sched.md
WB_MEM_SCHED -- requirements
Module: wb_mem_sched

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive m0 grants after which a pending m1 wins.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the wb_clk cycles a granted strobe may wait for ack.
REQ-003 SHALL have parameter AW, default 32, meaning the address width; data is fixed at 32 bits and select at 4 bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset; every port is listed in REQ-005 to REQ-019.
REQ-005 wb_clk  input  1  single clock; all state changes on the rising edge.
REQ-006 wb_rst  input  1  synchronous active-high reset.
REQ-007 wb_mX_adr_i (X=0 vcache, X=1 cpu)  input  AW  master address.
REQ-008 wb_mX_dat_i  input  32  master write data.
REQ-009 wb_mX_sel_i  input  4  master byte select.
REQ-010 wb_mX_cyc_i / wb_mX_stb_i / wb_mX_we_i  input  1 each  master cycle, strobe and write enable.
REQ-011 wb_mX_dat_o  output  32  read data; equals wb_s_dat_i for both masters.
REQ-012 wb_mX_ack_o  output  1  ack, routed only to the owning master.
REQ-013 wb_mX_err_o  output  1  watchdog error pulse, routed only to the owning master.
REQ-014 wb_s_adr_o / wb_s_dat_o / wb_s_sel_o  output  AW/32/4  slave request fields, muxed from the owner.
REQ-015 wb_s_cyc_o / wb_s_stb_o / wb_s_we_o  output  1 each  slave control, muxed from the owner and gated by grant.
REQ-016 wb_s_dat_i  input  32  slave read data.
REQ-017 wb_s_ack_i  input  1  slave ack.
REQ-018 mst_sel  output  2  current owner: 00 none, 01 m0, 10 m1.
REQ-019 starve_cnt  output  3  debug view of the m0 consecutive-grant counter.

Function
REQ-020 SHALL implement the FSM states IDLE, OWN0 and OWN1 with registered grant.
REQ-021 SHALL, in IDLE with only m0 cyc high at edge N, enter OWN0, with slave cyc/stb valid in cycle N+1; with only m1 cyc high, enter OWN1 the same way.
REQ-022 SHALL, with both cyc high in IDLE, pick m0 if starve_cnt < STARVE_MAX, else pick m1.
REQ-023 SHALL increment starve_cnt (saturating at STARVE_MAX) on each OWN0 entry while m1 cyc is high, and clear it on OWN1 entry or whenever m1 cyc is low in IDLE.
REQ-024 SHALL hold ownership while the owner's cyc is high, across multiple stb/ack beats, with no preemption.
REQ-025 SHALL return to IDLE on the edge after the owner drops cyc, giving a 1-cycle re-arbitration gap in which slave cyc is 0.
REQ-026 SHALL keep wb_s_cyc_o, wb_s_stb_o, mX_ack_o and mX_err_o at 0 for the non-owner at all times and for both masters in IDLE.
REQ-027 SHALL pass ack combinationally: wb_mX_ack_o = wb_s_ack_i AND (owner==X).
REQ-028 SHALL ignore wb_s_ack_i arriving in IDLE and not forward it to any master.

Reset
REQ-029 SHALL, on wb_rst high at an edge, go to IDLE and set mst_sel=00, starve_cnt=0, watchdog=0, and all cyc/stb/ack/err outputs=0; a reset during a transfer aborts it without an ack.
REQ-030 SHALL let the first grant occur at the first edge after wb_rst deasserts if a cyc is high.

Configuration
REQ-031 SHALL compile a watchdog when ARB_WATCHDOG_EN is defined: a counter runs while the owner's stb is high without ack, and at TIMEOUT it pulses wb_mX_err_o for 1 cycle, forces slave cyc/stb to 0 and enters IDLE; the counter clears on each ack.
REQ-032 SHALL, when ARB_WATCHDOG_EN is undefined, hold err_o at constant 0 and wait for ack indefinitely.

Verification
REQ-033 m0 single read (adr 0xF80000, 4-cycle slave ack) -> mst_sel=01 one cycle after cyc, m0_ack for 1 cycle, m0_dat_o=slave data, m1_ack stays 0.
REQ-034 m0 and m1 both continuously requesting, STARVE_MAX=4 -> grant sequence m0,m0,m0,m0,m1,m0..., separated by 1-cycle IDLE gaps.
REQ-035 m1 burst of 3 beats with cyc held while m0 requests -> m0 not granted until m1 drops cyc plus 1 cycle.
REQ-036 wb_rst asserted mid m1 write -> next cycle all outputs 0, mst_sel=00, no ack to m1.
REQ-037 ARB_WATCHDOG_EN defined, slave never acks, TIMEOUT=64 -> m0_err=1 exactly at cycle 64 of stb, then IDLE; undefined -> grant held, err stays 0.
